rv32_seq_ctrl: RTL

RV32_SEQ_CTRL -- requirements
Module: rv32_seq_ctrl

---
 rtl/rv32_seq_ctrl.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/rv32_seq_ctrl.sv
// rv32_seq_ctrl: multi-cycle sequencer for a small RV32 integer subset (R, I-ALU, LOAD, STORE).
//
// Ports:
//   clk, rst              clock and asynchronous active-low reset
//   start                 leave IDLE or HALT towards FETCH
//   halt_req              stop at the next instruction boundary
//   instr[31:0]           instruction word, decoded while in DECODE
//   imem_ready            instruction fetch completes
//   dmem_ready            data access completes
//   imem_req, dmem_req, dmem_we      memory strobes
//   ir_we, pc_we, reg_we, alu_src_imm datapath enables, operand-B select (1 = immediate)
//   alu_ctrl[3:0]         ALU operation, held from EXEC through WB
//   state[2:0]            current FSM state
//   busy, illegal, timeout status; illegal/timeout are sticky until reset
//   retired[31:0]         retired instruction count (wraps)
module rv32_seq_ctrl #(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        halt_req,
  input  logic [31:0] instr,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        ir_we,
  output logic        pc_we,
  output logic        reg_we,
  output logic        alu_src_imm,
  output logic [3:0]  alu_ctrl,
  output logic [2:0]  state,
  output logic        busy,
  output logic        illegal,
  output logic        timeout,
  output logic [31:0] retired
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StFetch  = 3'd1;
  localparam logic [2:0] StDecode = 3'd2;
  localparam logic [2:0] StExec   = 3'd3;
  localparam logic [2:0] StMem    = 3'd4;
  localparam logic [2:0] StWb     = 3'd5;
  localparam logic [2:0] StHalt   = 3'd6;
  localparam logic [2:0] StTrap   = 3'd7;

  localparam logic [1:0] ClsR     = 2'd0;
  localparam logic [1:0] ClsI     = 2'd1;
  localparam logic [1:0] ClsLoad  = 2'd2;
  localparam logic [1:0] ClsStore = 2'd3;

  localparam logic [3:0] AluAdd  = 4'd0;
  localparam logic [3:0] AluSub  = 4'd1;
  localparam logic [3:0] AluSll  = 4'd2;
  localparam logic [3:0] AluSlt  = 4'd3;
  localparam logic [3:0] AluSltu = 4'd4;
  localparam logic [3:0] AluXor  = 4'd5;
  localparam logic [3:0] AluSrl  = 4'd6;
  localparam logic [3:0] AluSra  = 4'd7;
  localparam logic [3:0] AluOr   = 4'd8;
  localparam logic [3:0] AluAnd  = 4'd9;

  // The counter only needs to reach MAX_WAIT-1 before the FSM leaves or traps.
  localparam int unsigned WaitW = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
  localparam logic [WaitW-1:0] WaitLimit = WaitW'(MAX_WAIT - 1);

  logic [2:0]       state_q, state_d;
  logic [1:0]       cls_q, cls_d;
  logic [3:0]       alu_q, alu_d;
  logic             rd_nz_q, rd_nz_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic             illegal_q, illegal_d;
  logic             timeout_q, timeout_d;
  logic             store_done_q, store_done_d;
  logic [31:0]      retired_q, retired_d;

  // funct7[5] selects SUB only on R-type; it selects SRA on both R and I shifts.
  function automatic logic [3:0] alu_decode(input logic [2:0] funct3, input logic alt,
                                            input logic is_r);
    logic [3:0] op;
    op = AluAdd;
    case (funct3)
      3'b000:  op = (is_r && alt) ? AluSub : AluAdd;
      3'b001:  op = AluSll;
      3'b010:  op = AluSlt;
      3'b011:  op = AluSltu;
      3'b100:  op = AluXor;
      3'b101:  op = alt ? AluSra : AluSrl;
      3'b110:  op = AluOr;
      default: op = AluAnd;
    endcase
    return op;
  endfunction

  always_comb begin
    state_d      = state_q;
    cls_d        = cls_q;
    alu_d        = alu_q;
    rd_nz_d      = rd_nz_q;
    wait_d       = wait_q;
    illegal_d    = illegal_q;
    timeout_d    = timeout_q;
    store_done_d = 1'b0;
    retired_d    = retired_q;

    case (state_q)
      StIdle, StHalt: begin
        if (start) state_d = StFetch;
      end
      StFetch: begin
        if (imem_ready) begin
          state_d = StDecode;
        end else if (wait_q == WaitLimit) begin
          state_d   = StTrap;
          timeout_d = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StDecode: begin
        state_d = StExec;
        rd_nz_d = |instr[11:7];
        case (instr[6:0])
          7'b0110011: begin
            cls_d = ClsR;
            alu_d = alu_decode(instr[14:12], instr[30], 1'b1);
          end
          7'b0010011: begin
            cls_d = ClsI;
            alu_d = alu_decode(instr[14:12], instr[30], 1'b0);
          end
          7'b0000011: begin
            cls_d = ClsLoad;
            alu_d = AluAdd;
          end
          7'b0100011: begin
            cls_d = ClsStore;
            alu_d = AluAdd;
          end
          default: begin
            state_d   = StTrap;
            illegal_d = 1'b1;
          end
        endcase
      end
      StExec: begin
        state_d = (cls_q == ClsLoad || cls_q == ClsStore) ? StMem : StWb;
      end
      StMem: begin
        if (dmem_ready) begin
          if (cls_q == ClsStore) begin
            store_done_d = 1'b1;
            retired_d    = retired_q + 32'd1;
            state_d      = halt_req ? StHalt : StFetch;
          end else begin
            state_d = StWb;
          end
        end else if (wait_q == WaitLimit) begin
          state_d   = StTrap;
          timeout_d = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StWb: begin
        retired_d = retired_q + 32'd1;
        state_d   = halt_req ? StHalt : StFetch;
      end
      default: state_d = StTrap;
    endcase

    // Fresh wait budget on every entry into a waiting state.
    if (state_d != state_q && (state_d == StFetch || state_d == StMem)) wait_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      cls_q        <= ClsR;
      alu_q        <= AluAdd;
      rd_nz_q      <= 1'b0;
      wait_q       <= '0;
      illegal_q    <= 1'b0;
      timeout_q    <= 1'b0;
      store_done_q <= 1'b0;
      retired_q    <= 32'd0;
    end else begin
      state_q      <= state_d;
      cls_q        <= cls_d;
      alu_q        <= alu_d;
      rd_nz_q      <= rd_nz_d;
      wait_q       <= wait_d;
      illegal_q    <= illegal_d;
      timeout_q    <= timeout_d;
      store_done_q <= store_done_d;
      retired_q    <= retired_d;
    end
  end

  // Strobes are decoded purely from registered state; a completed store raises pc_we
  // for the single cycle after its dmem_ready edge.
  always_comb begin
    imem_req    = (state_q == StFetch);
    ir_we       = (state_q == StDecode);
    dmem_req    = (state_q == StMem);
    dmem_we     = (state_q == StMem) && (cls_q == ClsStore);
    pc_we       = (state_q == StWb) || store_done_q;
    reg_we      = (state_q == StWb) && rd_nz_q;
    alu_src_imm = (state_q == StExec || state_q == StMem || state_q == StWb) && (cls_q != ClsR);
    alu_ctrl    = alu_q;
    state       = state_q;
    busy        = (state_q >= StFetch) && (state_q <= StWb);
    illegal     = illegal_q;
    timeout     = timeout_q;
    retired     = retired_q;
  end

endmodule
